// File: rtl/buffer_reader.sv
// buffer_reader: consumer-side controller for an external DEPTH x DW buffer.
// Tracks buffer occupancy from the writer's strobe, issues single-cycle read
// strobes, registers the returned word and hands it downstream over
// valid/ready. Reads run as BURST-word bursts or as a flush-driven drain.
// Optional build macro BUF_READER_STATS_EN adds the drained/max_count outputs.
module buffer_reader #(
   parameter int unsigned DW    = 16,
   parameter int unsigned DEPTH = 8,
   parameter int unsigned BURST = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   wr_seen,
   input  logic                   flush,
   output logic                   buf_rd,
   input  logic [DW-1:0]          buf_data,
   output logic [DW-1:0]          m_data,
   output logic                   m_valid,
   input  logic                   m_ready,
   output logic [$clog2(DEPTH):0] count,
   output logic                   busy,
   output logic                   overflow,
   output logic                   underflow
`ifdef BUF_READER_STATS_EN
   ,
   output logic [15:0]            drained,
   output logic [$clog2(DEPTH):0] max_count
`endif
);

   localparam int unsigned CW = $clog2(DEPTH) + 1;
   localparam logic [CW-1:0] FULL    = CW'(DEPTH);
   localparam logic [CW-1:0] BURST_N = CW'(BURST);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_BURST,
      ST_FLUSH
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] count_q, count_d;
   logic [CW-1:0] burst_cnt_q, burst_cnt_d;
   logic [DW-1:0] m_data_q, m_data_d;
   logic          m_valid_q, m_valid_d;
   logic          overflow_q, overflow_d;
   logic          underflow_q, underflow_d;
   logic          load;

   // A read is issued whenever a word is stored, the output stage can take it
   // and the controller is in an active read mode.
   always_comb begin
      load = (count_q != '0) && (!m_valid_q || m_ready) && (state_q != ST_IDLE);
   end

   assign buf_rd    = load;
   assign m_data    = m_data_q;
   assign m_valid   = m_valid_q;
   assign count     = count_q;
   assign busy      = (state_q != ST_IDLE);
   assign overflow  = overflow_q;
   assign underflow = underflow_q;

   // Read-mode sequencing: burst when enough words are stored, drain on flush.
   always_comb begin
      state_d     = state_q;
      burst_cnt_d = burst_cnt_q;
      if (load && (burst_cnt_q != '0)) begin
         burst_cnt_d = burst_cnt_q - 1'b1;
      end
      case (state_q)
         ST_IDLE: begin
            if (flush && (count_q != '0)) begin
               state_d = ST_FLUSH;
            end else if (count_q >= BURST_N) begin
               state_d     = ST_BURST;
               burst_cnt_d = BURST_N;
            end
         end
         ST_BURST: begin
            // Flush arriving mid-burst takes effect once the current word is read.
            if (load) begin
               if (burst_cnt_q == CW'(1)) begin
                  state_d = ST_IDLE;
               end else if (flush) begin
                  state_d = ST_FLUSH;
               end
            end
         end
         ST_FLUSH: begin
            if ((count_q == '0) && !flush) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Occupancy tracking and the sticky error flags.
   always_comb begin
      count_d     = count_q;
      overflow_d  = overflow_q;
      underflow_d = underflow_q;
      case ({wr_seen, load})
         2'b10: begin
            if (count_q == FULL) begin
               overflow_d = 1'b1;
            end else begin
               count_d = count_q + 1'b1;
            end
         end
         2'b01: count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
      if (load && (count_q == '0)) begin
         underflow_d = 1'b1;
      end
   end

   // Output stage: capture the buffer word on a read, retire it on ready.
   always_comb begin
      m_data_d  = m_data_q;
      m_valid_d = m_valid_q;
      if (load) begin
         m_data_d  = buf_data;
         m_valid_d = 1'b1;
      end else if (m_ready) begin
         m_valid_d = 1'b0;
      end
   end

   // State and datapath registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         count_q     <= '0;
         burst_cnt_q <= '0;
         m_data_q    <= '0;
         m_valid_q   <= 1'b0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         count_q     <= count_d;
         burst_cnt_q <= burst_cnt_d;
         m_data_q    <= m_data_d;
         m_valid_q   <= m_valid_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

`ifdef BUF_READER_STATS_EN
   logic [15:0]   drained_q, drained_d;
   logic [CW-1:0] max_count_q, max_count_d;

   // Transfer counter (wraps naturally) and occupancy high-water mark.
   always_comb begin
      drained_d   = drained_q;
      max_count_d = max_count_q;
      if (m_valid_q && m_ready) begin
         drained_d = drained_q + 16'd1;
      end
      if (count_d > max_count_q) begin
         max_count_d = count_d;
      end
   end

   // Statistics registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         drained_q   <= '0;
         max_count_q <= '0;
      end else begin
         drained_q   <= drained_d;
         max_count_q <= max_count_d;
      end
   end

   assign drained   = drained_q;
   assign max_count = max_count_q;
`endif

endmodule
